// File: rtl/sub32_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sub32_serial_if : start/done operand and result bundle for sub32     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sub32_serial_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b, bi,
        input  d, bo, ov, busy, done
    );

    modport slave (
        input  start, a, b, bi,
        output d, bo, ov, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sub32_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sub32_serial : 32-bit a - b - bi, one nibble per clock, LSB first    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sub32_serial (
    input  wire logic        clk,
    input  wire logic        reset_n,
    sub32_serial_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [27:0] r_res;
    logic        r_carry;
    logic [2:0]  r_cnt;
    logic [31:0] r_d;
    logic        r_bo;
    logic        r_ov;
    logic        w_busy;
    logic        w_done;
    logic [4:0]  w_sum;
    logic [3:0]  w_lo3;

    // Operands shift right, so the active nibble is always bits [3:0].
    assign w_sum = {1'b0, r_a[3:0]} + {1'b0, ~r_b[3:0]} + {4'd0, r_carry};
    // Lower three bits alone; their carry-out is the carry into bit 31 on the last step.
    assign w_lo3 = {1'b0, r_a[2:0]} + {1'b0, ~r_b[2:0]} + {3'd0, r_carry};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_res   <= 28'd0;
            r_carry <= 1'b0;
            r_cnt   <= 3'd0;
            r_d     <= 32'd0;
            r_bo    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= ~bus.bi;
                        r_cnt   <= 3'd0;
                    end
                end
                CALC: begin
                    r_a     <= {4'd0, r_a[31:4]};
                    r_b     <= {4'd0, r_b[31:4]};
                    r_res   <= {w_sum[3:0], r_res[27:4]};
                    r_carry <= w_sum[4];
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_d  <= {w_sum[3:0], r_res};
                        r_bo <= ~w_sum[4];
                        r_ov <= w_sum[4] ^ w_lo3[3];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.d    = r_d;
    assign bus.bo   = r_bo;
    assign bus.ov   = r_ov;
    assign bus.busy = w_busy;
    assign bus.done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_sub32_serial.sv
`default_nettype none
// Bench for sub32_serial: arithmetic/timing model plus directed literal checks.
module tb_sub32_serial;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sub32_serial_if bus ();

    sub32_serial dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } res_t;

    // Reference: plain integer arithmetic on the true values.
    function automatic res_t ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bi);
        res_t   r;
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint sr;
        ua   = longint'({32'd0, a});
        ub   = longint'({32'd0, b});
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sr   = sa - sb - longint'(bi);
        r.d  = a - b - {31'd0, bi};
        r.bo = (ua < ub + longint'(bi));
        r.ov = (sr < -64'sd2147483648) || (sr > 64'sd2147483647);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing model: phase counts edges since the accepting edge; 9 means done cycle.
    int   m_phase = 0;
    res_t m_res   = '0;
    res_t p_res   = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_res   <= '0;
            p_res   <= '0;
        end else if (m_phase == 0) begin
            if (bus.start) begin
                p_res   <= ref_sub(bus.a, bus.b, bus.bi);
                m_phase <= 1;
            end
        end else if (m_phase == 9) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == 8) m_res <= p_res;
        end
    end

    always @(negedge clk) begin
        chk("model_busy", {31'd0, bus.busy}, {31'd0, (m_phase != 0)});
        chk("model_done", {31'd0, bus.done}, {31'd0, (m_phase == 9)});
        chk("model_d",    bus.d,             m_res.d);
        chk("model_bo",   {31'd0, bus.bo},   {31'd0, m_res.bo});
        chk("model_ov",   {31'd0, bus.ov},   {31'd0, m_res.ov});
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic [31:0] ed, input logic ebo, input logic eov, input string nm);
        int cyc;
        int busyc;
        cyc   = 0;
        busyc = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bi = bi; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        if (bus.busy) busyc++;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busyc++;
        end
        if (!bus.done) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
        end else begin
            chk({nm, "_latency"}, cyc, 32'd9);
            chk({nm, "_busycycles"}, busyc, 32'd9);
            chk({nm, "_d"}, bus.d, ed);
            chk({nm, "_bo"}, {31'd0, bus.bo}, {31'd0, ebo});
            chk({nm, "_ov"}, {31'd0, bus.ov}, {31'd0, eov});
        end
    endtask

    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_d", bus.d, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        reset_n = 1'b1;

        run_op(32'd5,          32'd3,          1'b0, 32'h00000002, 1'b0, 1'b0, "basic");
        run_op(32'd0,          32'd1,          1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, "uwrap");
        run_op(32'h80000000,   32'd1,          1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, "sovf");
        run_op(32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h80000000, 1'b1, 1'b1, "both");
        run_op(32'h00001234,   32'h00001234,   1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "eq_bi");

        // Borrow-in with operands and start disturbed mid-operation.
        @(negedge clk);
        bus.a = 32'h10; bus.b = 32'h0; bus.bi = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            if (cyc == 3) begin
                bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.bi = 1'b0; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("held_latency", cyc, 32'd9);
        chk("held_d", bus.d, 32'h0000000F);
        chk("held_bo", {31'd0, bus.bo}, 32'd0);
        chk("held_ov", {31'd0, bus.ov}, 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("held_no_restart", {31'd0, bus.busy}, 32'd0);
        count_done(12, ndone);
        chk("held_extra_done", ndone, 32'd0);

        // Reset in the 4th CALC cycle.
        @(negedge clk);
        bus.a = 32'h12345678; bus.b = 32'h1; bus.bi = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_d", bus.d, 32'd0);
        chk("rst_bo", {31'd0, bus.bo}, 32'd0);
        chk("rst_ov", {31'd0, bus.ov}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_done(12, ndone);
        chk("rst_no_done", ndone, 32'd0);
        run_op(32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, "post_rst");

        // Back-to-back with start held high.
        @(negedge clk);
        bus.a = 32'h100; bus.b = 32'h1; bus.bi = 1'b0; bus.start = 1'b1;
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b1_latency", cyc, 32'd9);
        chk("b2b1_d", bus.d, 32'h000000FF);
        bus.a = 32'hA; bus.b = 32'hB;
        @(negedge clk);
        chk("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("b2b_idle_hold", bus.d, 32'h000000FF);
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b2_latency", cyc, 32'd10);
        chk("b2b2_d", bus.d, 32'hFFFFFFFF);
        chk("b2b2_bo", {31'd0, bus.bo}, 32'd1);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
